sram_word_ctrl: RTL and testbench

- Front-end controller sitting directly upstream of the 512x8 behavioural SRAM in the cache data path.
- Accepts 32-bit word read and write requests over a valid/ready handshake.
- Serialises each request into byte-wide SRAM operations by driving sense_en, wen, addr and din.
- For reads, waits the SRAM output latency, assembles the four bytes, and returns the word over a valid/ready response channel.

---
 rtl/sram_ctrl_pkg.sv | 24 ++
 rtl/sram_be_scan.sv | 31 +++
 rtl/sram_behav.sv | 34 +++
 rtl/sram_word_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sram_word_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// ============================================================================
// Module  : sram_ctrl_pkg
// Brief   : Shared types and constants for the SRAM word controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RESP     = 3'd4
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_IDX_W = 2;
  localparam int WAIT_CNT_W = 3;

endpackage

`default_nettype wire

// File: rtl/sram_be_scan.sv
// ============================================================================
// Module  : sram_be_scan
// Brief   : Finds the lowest set byte-enable strictly above cur_idx (-1 = any).
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_be_scan
  import sram_ctrl_pkg::*;
(
  input  logic [WORD_BYTES-1:0]       be,
  input  logic signed [BYTE_IDX_W:0]  cur_idx,
  output logic [BYTE_IDX_W-1:0]       next_idx,
  output logic                        found
);

  // Descending scan so the lowest qualifying bit is the one left standing.
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    for (int i = WORD_BYTES - 1; i >= 0; i--) begin
      if (be[i] && (i > int'(cur_idx))) begin
        next_idx = BYTE_IDX_W'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_behav.sv
// ============================================================================
// Module  : sram_behav
// Brief   : Byte-wide SRAM with READ_WAIT-cycle registered read latency.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_behav #(
  parameter int READ_WAIT = 2,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              sense_en,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
  output logic [7:0]        dout
);

  logic [7:0] r_mem  [2**ADDR_W];
  logic [7:0] r_pipe [READ_WAIT];

  // Data is sampled with sense_en and walks READ_WAIT-1 further stages.
  always_ff @(posedge clk) begin
    if (wen) r_mem[addr] <= din;
    if (sense_en) r_pipe[0] <= r_mem[addr];
    for (int k = 1; k < READ_WAIT; k++) r_pipe[k] <= r_pipe[k-1];
  end

  assign dout = r_pipe[READ_WAIT-1];

endmodule

`default_nettype wire

// File: rtl/sram_word_ctrl.sv
// ============================================================================
// Module  : sram_word_ctrl
// Brief   : Serialises 32-bit word requests into byte-wide SRAM accesses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_word_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int READ_WAIT = 2,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-3:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_din,
  output logic              sram_wen,
  output logic              sram_sense_en,
  input  logic [7:0]        sram_dout
);

  state_t                    r_state;
  logic [BYTE_IDX_W-1:0]     r_byte_idx;
  logic [WAIT_CNT_W-1:0]     r_cnt;
  logic [ADDR_W-3:0]         r_addr;
  logic [31:0]               r_wdata;
  logic [3:0]                r_be;
  logic [31:0]               r_rdata;

  logic [BYTE_IDX_W-1:0]     w_first_idx;
  logic                      w_first_found;
  logic [BYTE_IDX_W-1:0]     w_next_idx;
  logic                      w_next_found;
  logic signed [BYTE_IDX_W:0] w_cur_idx;
  logic [BYTE_IDX_W-1:0]     w_idx_inc;
  logic [31:0]               w_rdata_cap;

  assign w_cur_idx = {1'b0, r_byte_idx};
  assign w_idx_inc = r_byte_idx + 1'b1;

  sram_be_scan u_scan_first (
    .be       (req_be),
    .cur_idx  ('1),
    .next_idx (w_first_idx),
    .found    (w_first_found)
  );

  sram_be_scan u_scan_next (
    .be       (r_be),
    .cur_idx  (w_cur_idx),
    .next_idx (w_next_idx),
    .found    (w_next_found)
  );

  always_comb begin
    w_rdata_cap = r_rdata;
    w_rdata_cap[{r_byte_idx, 3'b000} +: 8] = sram_dout;
  end

  // Strobes default low each cycle; each transition re-asserts what the next state needs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      sram_addr     <= '0;
      sram_din      <= '0;
      sram_wen      <= 1'b0;
      sram_sense_en <= 1'b0;
      r_byte_idx    <= '0;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_be          <= '0;
      r_rdata       <= '0;
    end else begin
      sram_wen      <= 1'b0;
      sram_sense_en <= 1'b0;
      case (r_state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_be      <= req_be;
            r_rdata   <= '0;
            if (!req_we) begin
              r_state       <= RD_ISSUE;
              r_byte_idx    <= '0;
              sram_sense_en <= 1'b1;
              sram_addr     <= {req_addr, {BYTE_IDX_W{1'b0}}};
            end else if (w_first_found) begin
              r_state    <= WR;
              r_byte_idx <= w_first_idx;
              sram_wen   <= 1'b1;
              sram_addr  <= {req_addr, w_first_idx};
              sram_din   <= req_wdata[{w_first_idx, 3'b000} +: 8];
            end else begin
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
            end
          end
        end
        WR: begin
          if (w_next_found) begin
            r_byte_idx <= w_next_idx;
            sram_wen   <= 1'b1;
            sram_addr  <= {r_addr, w_next_idx};
            sram_din   <= r_wdata[{w_next_idx, 3'b000} +: 8];
          end else begin
            r_state    <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= '0;
          end
        end
        RD_ISSUE: begin
          r_state <= RD_WAIT;
          r_cnt   <= WAIT_CNT_W'(READ_WAIT - 1);
        end
        RD_WAIT: begin
          if (r_cnt == '0) begin
            r_rdata <= w_rdata_cap;
            if (r_byte_idx == BYTE_IDX_W'(WORD_BYTES - 1)) begin
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= w_rdata_cap;
            end else begin
              r_state       <= RD_ISSUE;
              r_byte_idx    <= w_idx_inc;
              sram_sense_en <= 1'b1;
              sram_addr     <= {r_addr, w_idx_inc};
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_word_ctrl.sv
// ============================================================================
// Module  : tb_sram_word_ctrl
// Brief   : Directed self-checking bench for sram_word_ctrl with sram_behav.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_word_ctrl;

  localparam int READ_WAIT = 2;
  localparam int ADDR_W    = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-3:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic [3:0]        req_be = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_din;
  logic              sram_wen;
  logic              sram_sense_en;
  logic [7:0]        sram_dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int conflicts = 0;

  logic [16:0] wen_q[$];
  logic [8:0]  sense_addr_q[$];
  int          sense_cyc_q[$];

  sram_word_ctrl #(.READ_WAIT(READ_WAIT), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_be       (req_be),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .sram_addr    (sram_addr),
    .sram_din     (sram_din),
    .sram_wen     (sram_wen),
    .sram_sense_en(sram_sense_en),
    .sram_dout    (sram_dout)
  );

  sram_behav #(.READ_WAIT(READ_WAIT), .ADDR_W(ADDR_W)) u_sram (
    .clk      (clk),
    .sense_en (sram_sense_en),
    .wen      (sram_wen),
    .addr     (sram_addr),
    .din      (sram_din),
    .dout     (sram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sram_wen) wen_q.push_back({sram_addr, sram_din});
    if (sram_sense_en) begin
      sense_addr_q.push_back(sram_addr);
      sense_cyc_q.push_back(cyc);
    end
    if (sram_wen && sram_sense_en) conflicts++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wen_q.delete();
    sense_addr_q.delete();
    sense_cyc_q.delete();
  endtask

  // Presents one request and returns just after its accept edge.
  task automatic issue(input logic we, input logic [6:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~d; req_be = ~be;
  endtask

  task automatic do_req(input logic we, input logic [6:0] a, input logic [31:0] d,
                        input logic [3:0] be, output int lat, output logic [31:0] rd);
    issue(we, a, d, be);
    lat = 0;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
  endtask

  task automatic finish_resp();
    @(posedge clk); #1;
    chk("resp_drop", 64'(resp_valid), 64'd0);
    chk("ready_back", 64'(req_ready), 64'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] rd;
    logic [31:0] held;
    int seen;

    // Reset state
    @(posedge clk); #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_sram_addr", 64'(sram_addr), 64'd0);
    chk("rst_strobes", 64'({sram_wen, sram_sense_en, sram_din}), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    // Full-word write
    clear_logs();
    do_req(1'b1, 7'h05, 32'hDEADBEEF, 4'hF, lat, rd);
    chk("wr4_latency", 64'(lat), 64'd4);
    chk("wr4_rdata", 64'(rd), 64'd0);
    finish_resp();
    chk("wr4_count", 64'(wen_q.size()), 64'd4);
    if (wen_q.size() == 4) begin
      chk("wr4_b0", 64'(wen_q[0]), 64'h014EF);
      chk("wr4_b1", 64'(wen_q[1]), 64'h015BE);
      chk("wr4_b2", 64'(wen_q[2]), 64'h016AD);
      chk("wr4_b3", 64'(wen_q[3]), 64'h017DE);
    end

    // Full-word read
    clear_logs();
    do_req(1'b0, 7'h05, 32'h0, 4'h0, lat, rd);
    chk("rd_latency", 64'(lat), 64'd12);
    chk("rd_rdata", 64'(rd), 64'hDEADBEEF);
    finish_resp();
    chk("rd_sense_count", 64'(sense_addr_q.size()), 64'd4);
    chk("rd_no_wen", 64'(wen_q.size()), 64'd0);
    if (sense_addr_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("rd_sense_addr", 64'(sense_addr_q[i]), 64'(9'h014 + i));
        if (i > 0) chk("rd_sense_gap", 64'(sense_cyc_q[i] - sense_cyc_q[i-1]), 64'd3);
      end
    end

    // Partial write then read-back
    clear_logs();
    do_req(1'b1, 7'h05, 32'h11223344, 4'b0101, lat, rd);
    chk("wrp_latency", 64'(lat), 64'd2);
    finish_resp();
    chk("wrp_count", 64'(wen_q.size()), 64'd2);
    if (wen_q.size() == 2) begin
      chk("wrp_b0", 64'(wen_q[0]), 64'h01444);
      chk("wrp_b2", 64'(wen_q[1]), 64'h01622);
    end
    do_req(1'b0, 7'h05, 32'h0, 4'h0, lat, rd);
    chk("rdp_rdata", 64'(rd), 64'hDE22BE44);
    finish_resp();

    // Write with no enabled bytes
    clear_logs();
    do_req(1'b1, 7'h05, 32'hFFFFFFFF, 4'h0, lat, rd);
    chk("wr0_latency", 64'(lat), 64'd0);
    chk("wr0_rdata", 64'(rd), 64'd0);
    finish_resp();
    chk("wr0_no_activity", 64'(wen_q.size() + sense_addr_q.size()), 64'd0);

    // Top word address, top byte only
    clear_logs();
    do_req(1'b1, 7'h7F, 32'hA5000000, 4'b1000, lat, rd);
    chk("wrap_latency", 64'(lat), 64'd1);
    finish_resp();
    chk("wrap_count", 64'(wen_q.size()), 64'd1);
    if (wen_q.size() == 1) chk("wrap_b3", 64'(wen_q[0]), 64'h1FFA5);
    do_req(1'b0, 7'h7F, 32'h0, 4'h0, lat, rd);
    chk("wrap_rd_b3", 64'(rd[31:24]), 64'hA5);
    finish_resp();

    // Response backpressure
    resp_ready = 1'b0;
    do_req(1'b0, 7'h05, 32'h0, 4'h0, lat, rd);
    chk("bp_latency", 64'(lat), 64'd12);
    chk("bp_rdata", 64'(rd), 64'hDE22BE44);
    held = rd;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_stable", 64'(resp_rdata), 64'(held));
      chk("bp_ready_low", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    finish_resp();
    do_req(1'b1, 7'h06, 32'h0BADF00D, 4'hF, lat, rd);
    chk("after_bp_latency", 64'(lat), 64'd4);
    finish_resp();

    // Reset during RD_WAIT of byte 2
    issue(1'b0, 7'h05, 32'h0, 4'h0);
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_addr", 64'(sram_addr), 64'h016);
    chk("pre_rst_sense", 64'(sram_sense_en), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", 64'({req_ready, resp_valid, sram_wen, sram_sense_en, sram_din}), 64'd0);
    chk("async_rst_addr", 64'(sram_addr), 64'd0);
    chk("async_rst_rdata", 64'(resp_rdata), 64'd0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst2_ready", 64'(req_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    chk("rst2_no_resp", 64'(seen), 64'd0);
    do_req(1'b0, 7'h05, 32'h0, 4'h0, lat, rd);
    chk("rst2_rd_latency", 64'(lat), 64'd12);
    chk("rst2_rd_rdata", 64'(rd), 64'hDE22BE44);
    finish_resp();
    do_req(1'b0, 7'h06, 32'h0, 4'h0, lat, rd);
    chk("rst2_rd6_rdata", 64'(rd), 64'h0BADF00D);
    finish_resp();

    chk("wen_sense_exclusive", 64'(conflicts), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
